fx2_fifo_master: RTL

//  FPGA-side master for the FX2 slave-FIFO bus; the counterpart of the FX2 test fixture.

---
 rtl/fx2_fifo_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fx2_fifo_master.sv
// fx2_fifo_master: FPGA-side master for the FX2 slave-FIFO bus.
// Drains EP2 to rx_*, fills EP6 from tx_*. Macro FX2_AUTO_PKTEND_EN adds idle auto-PKTEND.
module fx2_fifo_master #(
   parameter logic [1:0] OUT_ADR        = 2'b00,
   parameter logic [1:0] IN_ADR         = 2'b10,
   parameter int         BURST_MAX      = 64,
   parameter int         PKTEND_TIMEOUT = 255
) (
   input  logic       ifclk,
   input  logic       reset_n,
   inout  wire  [7:0] fd,
   input  logic [3:0] flags,
   output logic [1:0] fifoadr,
   output logic       sloe,
   output logic       slrd,
   output logic       slwr,
   output logic       pktend,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       tx_flush
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_SETUP,
      S_READ,
      S_WR_SETUP,
      S_WRITE,
      S_PKTEND
   } state_t;

   localparam logic [7:0] BMAX = 8'(BURST_MAX);

   state_t     state, nxt;
   logic [7:0] burst;
   logic       burst_lt;
   logic       prio_wr;
   logic       dirty;
   logic       flush_pending;
   logic       auto_hit;
   logic       rd_req, wr_req;
   logic       fd_oe;
   logic       unused_ok;

   assign burst_lt = (burst < BMAX);
   assign rd_req   = ~flags[0] & rx_ready;
   assign wr_req   = (tx_valid & ~flags[1]) | (flush_pending & dirty);
   assign tx_ready = slwr;
   assign fd       = fd_oe ? tx_data : 8'hzz;

`ifdef FX2_AUTO_PKTEND_EN
   localparam logic [15:0] TMO = 16'(PKTEND_TIMEOUT);

   logic [15:0] idle_cnt;

   assign auto_hit  = (idle_cnt == TMO);
   assign unused_ok = ^flags[3:2];

   // Count idle cycles while unflushed IN data sits in the FX2
   always_ff @(posedge ifclk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
      end else if (slwr || state == S_PKTEND) begin
         idle_cnt <= '0;
      end else if (dirty && idle_cnt != 16'hffff) begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end
`else
   assign auto_hit  = 1'b0;
   assign unused_ok = ^{flags[3:2], (PKTEND_TIMEOUT != 0)};
`endif

   // Next-state and bus strobes
   always_comb begin
      nxt     = state;
      fifoadr = IN_ADR;
      sloe    = 1'b0;
      slrd    = 1'b0;
      slwr    = 1'b0;
      pktend  = 1'b0;
      fd_oe   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (rd_req && (!wr_req || !prio_wr)) begin
               nxt = S_RD_SETUP;
            end else if (wr_req) begin
               nxt = S_WR_SETUP;
            end
         end
         S_RD_SETUP: begin
            fifoadr = OUT_ADR;
            sloe    = 1'b1;
            nxt     = S_READ;
         end
         S_READ: begin
            fifoadr = OUT_ADR;
            sloe    = 1'b1;
            slrd    = rd_req & burst_lt;
            if (!slrd) nxt = S_IDLE;
         end
         S_WR_SETUP: begin
            nxt = S_WRITE;
         end
         S_WRITE: begin
            fd_oe = 1'b1;
            slwr  = tx_valid & ~flags[1] & burst_lt & ~flush_pending;
            if (!slwr) begin
               nxt = (flush_pending && dirty) ? S_PKTEND : S_IDLE;
            end
         end
         S_PKTEND: begin
            pktend = 1'b1;
            nxt    = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // State register and burst fairness toggle
   always_ff @(posedge ifclk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         prio_wr <= 1'b0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && nxt == S_RD_SETUP) prio_wr <= 1'b1;
         if (state == S_IDLE && nxt == S_WR_SETUP) prio_wr <= 1'b0;
      end
   end

   // Per-burst byte counter, saturating at BURST_MAX
   always_ff @(posedge ifclk or negedge reset_n) begin
      if (!reset_n) begin
         burst <= '0;
      end else if (state == S_RD_SETUP || state == S_WR_SETUP) begin
         burst <= '0;
      end else if ((slrd || slwr) && burst_lt) begin
         burst <= burst + 8'd1;
      end
   end

   // Capture EP2 bytes on each read strobe
   always_ff @(posedge ifclk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= slrd;
         if (slrd) rx_data <= fd;
      end
   end

   // Track uncommitted IN data and pending packet commit
   always_ff @(posedge ifclk or negedge reset_n) begin
      if (!reset_n) begin
         dirty         <= 1'b0;
         flush_pending <= 1'b0;
      end else if (state == S_PKTEND) begin
         dirty         <= 1'b0;
         flush_pending <= 1'b0;
      end else begin
         if (slwr) dirty <= 1'b1;
         if ((tx_flush && (dirty || slwr)) || auto_hit) begin
            flush_pending <= 1'b1;
         end
      end
   end

endmodule
